// File: rtl/seg_scan_driver_if.sv
// Bus between the display controller (master) and the 7-segment scan stage
// (slave). Segment patterns are common cathode, GFEDCBA, 1 = lit.
// The blink_mask signal exists only when SEG_BLINK_EN is defined.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [7*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en;
`ifdef SEG_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;
`endif
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_start;

  modport master (
`ifdef SEG_BLINK_EN
    output blink_mask,
`endif
    output digit_data,
    output dp_mask,
    output digit_en,
    input  seg_out,
    input  dp_out,
    input  an_out,
    input  frame_start
  );

  modport slave (
`ifdef SEG_BLINK_EN
    input  blink_mask,
`endif
    input  digit_data,
    input  dp_mask,
    input  digit_en,
    output seg_out,
    output dp_out,
    output an_out,
    output frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver.
// Each digit slot is SCAN_DIV cycles: BLANK_CYCLES dark, then the digit shown.
// All inputs are snapshotted at frame start so a frame never mixes old and
// new data. Outputs are registered from next-state values (no output lag).
// Optional blinking is enabled with the SEG_BLINK_EN macro.
module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_driver_if.slave  bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 7 * NUM_DIGITS;

  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]         SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  // Parameter sanity checks at elaboration
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
    $error("seg_scan_driver: need 1 <= BLANK_CYCLES < SCAN_DIV");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("seg_scan_driver: BLINK_FRAMES must be >= 1");
  end

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [DW-1:0]           snap_data_q, snap_data_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q, fs_d;

  logic                    capture;
  logic                    lit;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
  logic                    snap_phase_q, snap_phase_d;
`endif

  // Slot sequencing: counter runs across the whole slot, blank then show
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    capture = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    unique case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame snapshot and (optionally) blink phase bookkeeping
  always_comb begin
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;
    snap_en_d   = snap_en_q;
    if (capture) begin
      snap_data_d = bus.digit_data;
      snap_dp_d   = bus.dp_mask;
      snap_en_d   = bus.digit_en;
    end
`ifdef SEG_BLINK_EN
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    snap_blink_d  = snap_blink_q;
    snap_phase_d  = snap_phase_q;
    if (capture) begin
      snap_blink_d = bus.blink_mask;
      // Phase is latched before the frame counter advances so that the
      // first BLINK_FRAMES frames after reset are the visible phase.
      snap_phase_d = blink_phase_q;
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
`endif
  end

  // Output values for the upcoming cycle, from next state/index/snapshot
  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    an_d  = '0;
    fs_d  = capture;
`ifdef SEG_BLINK_EN
    lit = snap_en_d[idx_d] & ~(snap_blink_d[idx_d] & snap_phase_d);
`else
    lit = snap_en_d[idx_d];
`endif
    if ((state_d == ST_SHOW) && lit) begin
      an_d  = AN_ONE << idx_d;
      seg_d = snap_data_d[7*int'(idx_d) +: 7];
      dp_d  = snap_dp_d[idx_d];
    end
  end

  // State, snapshot and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BLANK;
      idx_q       <= '0;
      cnt_q       <= '0;
      snap_data_q <= '0;
      snap_dp_q   <= '0;
      snap_en_q   <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      an_q        <= '0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      snap_en_q   <= snap_en_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      fs_q        <= fs_d;
    end
  end

`ifdef SEG_BLINK_EN
  // Blink frame counter and phase registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_blink_q  <= '0;
      snap_phase_q  <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_blink_q  <= snap_blink_d;
      snap_phase_q  <= snap_phase_d;
    end
  end
`endif

  assign bus.seg_out     = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.an_out      = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2). A time-based model predicts the outputs each cycle.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = ND * SD;
  localparam int DW    = 7 * ND;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since reset release; everything follows from t.
  int            t = 0;
  logic          m_valid = 1'b0;
  logic [6:0]    m_seg;
  logic          m_dp;
  logic [ND-1:0] m_an;
  logic          m_fs;
  logic [DW-1:0] s_data;
  logic [ND-1:0] s_dp, s_en, s_blink;
  logic          s_ph;

  always @(posedge clk) begin
    int  slot, off;
    logic on;
    if (!rst_n) begin
      t = 0;
      m_seg = '0; m_dp = 1'b0; m_an = '0; m_fs = 1'b0;
      s_data = '0; s_dp = '0; s_en = '0; s_blink = '0; s_ph = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (t % FRAME == 0) begin
        s_data = bus.digit_data;
        s_dp   = bus.dp_mask;
        s_en   = bus.digit_en;
`ifdef SEG_BLINK_EN
        s_blink = bus.blink_mask;
`else
        s_blink = '0;
`endif
        s_ph = (((t / FRAME) / BF) % 2) == 1;
        m_fs = 1'b1;
      end
      t = t + 1;
      slot = (t % FRAME) / SD;
      off  = t % SD;
      on = (off >= BC) && s_en[slot] && !(s_blink[slot] && s_ph);
      m_an  = on ? (ND'(1) << slot) : '0;
      m_seg = on ? s_data[slot*7 +: 7] : 7'h00;
      m_dp  = on ? s_dp[slot] : 1'b0;
    end
    m_valid = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg_out", 32'(bus.seg_out), 32'(m_seg));
      chk("dp_out", 32'(bus.dp_out), 32'(m_dp));
      chk("an_out", 32'(bus.an_out), 32'(m_an));
      chk("frame_start", 32'(bus.frame_start), 32'(m_fs));
    end
  end

  task automatic wait_t(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (t == target) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL wait_t actual=%0d required=%0d", t, target);
  endtask

  task automatic lit_an_seg(input string name, input logic [ND-1:0] an, input logic [6:0] seg, input logic dp);
    chk({name, "_an"}, 32'(bus.an_out), 32'(an));
    chk({name, "_seg"}, 32'(bus.seg_out), 32'(seg));
    chk({name, "_dp"}, 32'(bus.dp_out), 32'(dp));
  endtask

  initial begin
    bus.digit_data = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    bus.dp_mask    = 4'b0100;
    bus.digit_en   = 4'b1111;
`ifdef SEG_BLINK_EN
    bus.blink_mask = '0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    lit_an_seg("in_reset", 4'b0000, 7'h00, 1'b0);
    chk("in_reset_fs", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;

    // Reset exit and scan order
    wait_t(1);  chk("first_fs", 32'(bus.frame_start), 32'd1);
                lit_an_seg("first_blank", 4'b0000, 7'h00, 1'b0);
    wait_t(2);  lit_an_seg("d0_show", 4'b0001, 7'h3F, 1'b0);
    wait_t(7);  lit_an_seg("d0_last", 4'b0001, 7'h3F, 1'b0);
    wait_t(8);  lit_an_seg("d1_blank", 4'b0000, 7'h00, 1'b0);
    wait_t(10); lit_an_seg("d1_show", 4'b0010, 7'h06, 1'b0);
    wait_t(18); lit_an_seg("d2_show", 4'b0100, 7'h5B, 1'b1);
    wait_t(26); lit_an_seg("d3_show", 4'b1000, 7'h4F, 1'b0);
    wait_t(32); lit_an_seg("wrap_blank", 4'b0000, 7'h00, 1'b0);
    wait_t(33); chk("second_fs", 32'(bus.frame_start), 32'd1);
    wait_t(34); lit_an_seg("wrap_d0", 4'b0001, 7'h3F, 1'b0);

    // Tear-free update mid-frame
    wait_t(76); bus.digit_data[6:0] = 7'h66;
    wait_t(90); lit_an_seg("old_frame_d3", 4'b1000, 7'h4F, 1'b0);
    wait_t(98); lit_an_seg("new_frame_d0", 4'b0001, 7'h66, 1'b0);

    // Enable mask
    wait_t(100); bus.digit_en = 4'b1010;
    wait_t(130); lit_an_seg("en_slot0", 4'b0000, 7'h00, 1'b0);
    wait_t(138); lit_an_seg("en_slot1", 4'b0010, 7'h06, 1'b0);
    wait_t(146); lit_an_seg("en_slot2", 4'b0000, 7'h00, 1'b0);
    wait_t(154); lit_an_seg("en_slot3", 4'b1000, 7'h4F, 1'b0);
    wait_t(158); bus.digit_en = 4'b1111;

    // Reset during digit2 show
    wait_t(180); lit_an_seg("pre_rst_d2", 4'b0100, 7'h5B, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    lit_an_seg("mid_rst", 4'b0000, 7'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_t(1); chk("restart_fs", 32'(bus.frame_start), 32'd1);
    wait_t(2); lit_an_seg("restart_d0", 4'b0001, 7'h66, 1'b0);

`ifdef SEG_BLINK_EN
    // Blink: digit0 lit frames 0-1, dark 2-3, lit 4-5
    @(negedge clk);
    bus.blink_mask = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_t(2);   lit_an_seg("blink_f0", 4'b0001, 7'h66, 1'b0);
    wait_t(34);  lit_an_seg("blink_f1", 4'b0001, 7'h66, 1'b0);
    wait_t(66);  lit_an_seg("blink_f2", 4'b0000, 7'h00, 1'b0);
    wait_t(74);  lit_an_seg("blink_f2_d1", 4'b0010, 7'h06, 1'b0);
    wait_t(98);  lit_an_seg("blink_f3", 4'b0000, 7'h00, 1'b0);
    wait_t(130); lit_an_seg("blink_f4", 4'b0001, 7'h66, 1'b0);
`endif

    // Randomized inputs and occasional resets, checked by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) bus.digit_data = DW'($urandom);
      if ($urandom_range(0, 9) == 0) bus.dp_mask = ND'($urandom);
      if ($urandom_range(0, 9) == 0) bus.digit_en = ND'($urandom | $urandom);
`ifdef SEG_BLINK_EN
      if ($urandom_range(0, 19) == 0) bus.blink_mask = ND'($urandom);
`endif
      if (rst_n && $urandom_range(0, 399) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 2) == 0) rst_n = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog t=%0d", t);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
